// File: rtl/jericalla_sequencer.sv
// Instruction issue controller for the jericalla 2-stage datapath.
// Fetches from an async ROM by pc, and tracks the register writes of the
// words in D and E in a 2-entry scoreboard. A bubble is inserted whenever the
// next word reads a register that one of those words will write.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; NOP on instr_out
// RUN   | issuing one word per cycle, or a bubble on hazard
// DRAIN | program issued or halted; feeding NOPs until D and E are empty
// DONE  | single-cycle completion pulse, then back to IDLE
module jericalla_sequencer #(
  parameter int          PC_W      = 8,
  parameter int          CNT_W     = 16,
  parameter logic [7:0]  WE_MASK   = 8'h0F,
  parameter logic [17:0] NOP_INSTR = 18'h38000
) (
  input  logic             clk_jericalla,
  input  logic             rst_jericalla,
  input  logic             start,
  input  logic             halt,
  input  logic [PC_W-1:0]  pc_base,
  input  logic [PC_W-1:0]  prog_len,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [17:0]      imem_data,
  output logic [17:0]      instr_out,
  output logic             instr_valid,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issue_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   len_q, len_d;
  logic [17:0]       instr_d;
  logic              valid_d;
  logic              stall_d;
  logic [CNT_W-1:0]  issue_d, stall_cnt_d;
  logic [CNT_W-1:0]  issue_sat, stall_sat;

  // Scoreboard: D mirrors the word on instr_out, E is the word one stage later
  logic              d_we_q, e_we_q, e_valid_q;
  logic [4:0]        d_wa_q, e_wa_q;

  logic [4:0]        cand_ra1, cand_ra2;
  logic              hit_d, hit_e, hazard;

  assign imem_addr = pc_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  // Hazard detect on the ROM word about to be issued
  always_comb begin
    cand_ra1 = imem_data[9:5];
    cand_ra2 = imem_data[4:0];
    hit_d    = d_we_q && ((cand_ra1 == d_wa_q) || (cand_ra2 == d_wa_q));
    hit_e    = e_we_q && ((cand_ra1 == e_wa_q) || (cand_ra2 == e_wa_q));
    hazard   = (state_q == S_RUN) && (hit_d || hit_e);
  end

  // Saturating increments for the run statistics
  always_comb begin
    issue_sat = (issue_count == '1) ? issue_count : issue_count + CNT_W'(1);
    stall_sat = (stall_count == '1) ? stall_count : stall_count + CNT_W'(1);
  end

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    instr_d     = NOP_INSTR;
    valid_d     = 1'b0;
    stall_d     = 1'b0;
    issue_d     = issue_count;
    stall_cnt_d = stall_count;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = prog_len;
          pc_d        = pc_base;
          issue_d     = '0;
          stall_cnt_d = '0;
          state_d     = (prog_len == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_DRAIN;
        end else if (hazard) begin
          stall_d     = 1'b1;
          stall_cnt_d = stall_sat;
        end else begin
          instr_d = imem_data;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          issue_d = issue_sat;
          if ((issue_count + CNT_W'(1)) == CNT_W'(len_q)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!instr_valid && !e_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_jericalla) begin
    if (rst_jericalla) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue register, pc, counters and scoreboard shift
  always_ff @(posedge clk_jericalla) begin
    if (rst_jericalla) begin
      pc_q        <= '0;
      len_q       <= '0;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      stall       <= 1'b0;
      issue_count <= '0;
      stall_count <= '0;
      d_we_q      <= 1'b0;
      d_wa_q      <= '0;
      e_we_q      <= 1'b0;
      e_wa_q      <= '0;
      e_valid_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      len_q       <= len_d;
      instr_out   <= instr_d;
      instr_valid <= valid_d;
      stall       <= stall_d;
      issue_count <= issue_d;
      stall_count <= stall_cnt_d;
      d_we_q      <= WE_MASK[instr_d[17:15]] & valid_d;
      d_wa_q      <= instr_d[14:10];
      e_we_q      <= d_we_q;
      e_wa_q      <= d_wa_q;
      e_valid_q   <= instr_valid;
    end
  end

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Bench for jericalla_sequencer: directed scenarios plus random programs
// compared cycle by cycle against a schedule computed from the issue rules.
module tb_jericalla_sequencer;
  localparam logic [17:0] NOP = 18'h38000;
  localparam int MAXT = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  pc_base = '0;
  logic [7:0]  prog_len = '0;
  logic [7:0]  imem_addr;
  logic [17:0] imem_data;
  logic [17:0] instr_out;
  logic        instr_valid, stall, busy, done;
  logic [15:0] issue_count, stall_count;

  logic [17:0] rom [256];
  logic [7:0]  wem = 8'h0F;
  int tests = 0;
  int fails = 0;

  int          n_tr, done_idx;
  logic        tr_valid [MAXT];
  logic [17:0] tr_instr [MAXT];
  logic        tr_stall [MAXT];
  logic        tr_busy  [MAXT];
  logic [7:0]  tr_addr  [MAXT];
  int          d_idx    [256];

  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr];

  jericalla_sequencer dut (
    .clk_jericalla(clk),
    .rst_jericalla(rst),
    .start(start),
    .halt(halt),
    .pc_base(pc_base),
    .prog_len(prog_len),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .instr_out(instr_out),
    .instr_valid(instr_valid),
    .stall(stall),
    .busy(busy),
    .done(done),
    .issue_count(issue_count),
    .stall_count(stall_count)
  );

  function automatic logic [17:0] mk(input int op, input int wa, input int ra1, input int ra2);
    return {op[2:0], wa[4:0], ra1[4:0], ra2[4:0]};
  endfunction

  // Each word enters D one cycle after its predecessor, and no earlier than
  // three cycles after any earlier writer of a register it reads.
  // Index 0 is the first cycle after start is accepted.
  function automatic int model_schedule(input logic [7:0] base, input int len);
    int t;
    logic [17:0] w, p;
    if (len == 0) return 1;
    for (int i = 0; i < len; i++) begin
      w = rom[8'(base + i)];
      t = (i == 0) ? 1 : d_idx[i-1] + 1;
      for (int j = 0; j < i; j++) begin
        p = rom[8'(base + j)];
        if (wem[p[17:15]] && (p[14:10] == w[9:5] || p[14:10] == w[4:0]) && d_idx[j] + 3 > t)
          t = d_idx[j] + 3;
      end
      d_idx[i] = t;
    end
    return d_idx[len-1] + 3;
  endfunction

  // Start a program and record outputs each cycle until done (bounded)
  task automatic run_prog(input logic [7:0] base, input logic [7:0] len,
                          input int halt_at, input int restart_at);
    @(negedge clk);
    pc_base  = base;
    prog_len = len;
    start    = 1'b1;
    done_idx = -1;
    n_tr     = 0;
    for (int k = 0; k < MAXT && done_idx < 0; k++) begin
      @(negedge clk);
      start       = 1'b0;
      tr_valid[k] = instr_valid;
      tr_instr[k] = instr_out;
      tr_stall[k] = stall;
      tr_busy[k]  = busy;
      tr_addr[k]  = imem_addr;
      n_tr        = k + 1;
      if (done) done_idx = k;
      halt = (k == halt_at);
      if (k == restart_at) begin
        start    = 1'b1;
        pc_base  = 8'h80;
        prog_len = 8'd3;
      end
    end
    halt  = 1'b0;
    start = 1'b0;
    tests++;
    if (done_idx < 0) begin
      fails++;
      $display("FAIL run_timeout: no done within %0d cycles (base %h len %0d)", MAXT, base, len);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({instr_out, instr_valid, stall, busy, done, imem_addr} !== {NOP, 4'b0000, 8'h00}) begin
      fails++;
      $display("FAIL reset_outputs: got instr %h v%b s%b b%b d%b addr %h, exp %h 0 0 0 0 00",
               instr_out, instr_valid, stall, busy, done, imem_addr, NOP);
    end
    tests++;
    if (issue_count !== 16'd0 || stall_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_counts: got %0d/%0d, exp 0/0", issue_count, stall_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_independent();
    rom[8'h10] = mk(0, 1, 2, 3);
    rom[8'h11] = mk(1, 4, 5, 6);
    rom[8'h12] = mk(2, 7, 8, 9);
    rom[8'h13] = mk(3, 10, 11, 12);
    run_prog(8'h10, 8'd4, -1, -1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (tr_valid[i+1] !== 1'b1 || tr_instr[i+1] !== rom[8'(8'h10 + i)]) begin
        fails++;
        $display("FAIL indep_issue%0d: got v%b %h, exp v1 %h", i, tr_valid[i+1], tr_instr[i+1], rom[8'(8'h10 + i)]);
      end
    end
    tests++;
    if (done_idx !== 7 || stall_count !== 16'd0 || issue_count !== 16'd4) begin
      fails++;
      $display("FAIL indep_done: got done@%0d stalls %0d issues %0d, exp 7 0 4", done_idx, stall_count, issue_count);
    end
  endtask

  task automatic test_raw_two_bubbles();
    rom[8'h20] = mk(0, 5, 1, 2);
    rom[8'h21] = mk(1, 6, 5, 3);
    run_prog(8'h20, 8'd2, -1, -1);
    tests++;
    if (tr_valid[1] !== 1'b1 || tr_valid[4] !== 1'b1 || tr_instr[4] !== rom[8'h21]) begin
      fails++;
      $display("FAIL raw2_spacing: got v1=%b v4=%b instr4=%h, exp 1 1 %h", tr_valid[1], tr_valid[4], tr_instr[4], rom[8'h21]);
    end
    tests++;
    if ({tr_valid[2], tr_valid[3], tr_stall[2], tr_stall[3]} !== 4'b0011) begin
      fails++;
      $display("FAIL raw2_bubbles: got valid %b%b stall %b%b, exp 00 11", tr_valid[2], tr_valid[3], tr_stall[2], tr_stall[3]);
    end
    tests++;
    if (stall_count !== 16'd2 || done_idx !== 7) begin
      fails++;
      $display("FAIL raw2_counts: got stalls %0d done@%0d, exp 2 7", stall_count, done_idx);
    end
  endtask

  task automatic test_raw_one_bubble();
    rom[8'h28] = mk(0, 5, 1, 2);
    rom[8'h29] = mk(7, 9, 1, 2);
    rom[8'h2A] = mk(1, 6, 3, 5);
    run_prog(8'h28, 8'd3, -1, -1);
    tests++;
    if (tr_valid[3] !== 1'b0 || tr_stall[3] !== 1'b1 || tr_instr[4] !== rom[8'h2A]) begin
      fails++;
      $display("FAIL raw1_bubble: got v3=%b s3=%b instr4=%h, exp 0 1 %h", tr_valid[3], tr_stall[3], tr_instr[4], rom[8'h2A]);
    end
    tests++;
    if (stall_count !== 16'd1 || issue_count !== 16'd3) begin
      fails++;
      $display("FAIL raw1_counts: got stalls %0d issues %0d, exp 1 3", stall_count, issue_count);
    end
  endtask

  task automatic test_no_write();
    rom[8'h40] = mk(4, 5, 1, 2);
    rom[8'h41] = mk(0, 6, 5, 3);
    run_prog(8'h40, 8'd2, -1, -1);
    tests++;
    if (tr_instr[2] !== rom[8'h41] || stall_count !== 16'd0 || done_idx !== 5) begin
      fails++;
      $display("FAIL nowrite: got instr2 %h stalls %0d done@%0d, exp %h 0 5", tr_instr[2], stall_count, done_idx, rom[8'h41]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr;
    rom[8'hFE] = mk(0, 1, 2, 3);
    rom[8'hFF] = mk(1, 4, 5, 6);
    rom[8'h00] = mk(2, 7, 8, 9);
    rom[8'h01] = mk(3, 10, 11, 12);
    run_prog(8'hFE, 8'd4, -1, -1);
    for (int k = 0; k < 4; k++) begin
      exp_addr = 8'(8'hFE + k);
      tests++;
      if (tr_addr[k] !== exp_addr || tr_instr[k+1] !== rom[exp_addr]) begin
        fails++;
        $display("FAIL wrap_addr%0d: got addr %h instr %h, exp %h %h", k, tr_addr[k], tr_instr[k+1], exp_addr, rom[exp_addr]);
      end
    end
    tests++;
    if (issue_count !== 16'd4) begin
      fails++;
      $display("FAIL wrap_issues: got %0d, exp 4", issue_count);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 6; i++) rom[8'(8'h30 + i)] = mk(i % 4, 10 + i, 20 + i, 26 + i);
    run_prog(8'h30, 8'd6, 1, -1);
    tests++;
    if (tr_valid[1] !== 1'b1 || tr_valid[2] !== 1'b0 || tr_stall[2] !== 1'b0) begin
      fails++;
      $display("FAIL halt_stop: got v1=%b v2=%b s2=%b, exp 1 0 0", tr_valid[1], tr_valid[2], tr_stall[2]);
    end
    tests++;
    if (issue_count !== 16'd1 || done_idx !== 4) begin
      fails++;
      $display("FAIL halt_counts: got issues %0d done@%0d, exp 1 4", issue_count, done_idx);
    end
  endtask

  task automatic test_len_zero();
    int nv;
    run_prog(8'h50, 8'd0, -1, -1);
    nv = 0;
    for (int k = 0; k < n_tr; k++) if (tr_valid[k] !== 1'b0) nv++;
    tests++;
    if (done_idx < 1 || done_idx > 2 || issue_count !== 16'd0 || nv != 0) begin
      fails++;
      $display("FAIL len0: got done@%0d issues %0d valid_cycles %0d, exp done@1..2 0 0", done_idx, issue_count, nv);
    end
  endtask

  task automatic test_start_while_busy();
    run_prog(8'h10, 8'd4, -1, 2);
    tests++;
    if (done_idx !== 7 || issue_count !== 16'd4 || tr_instr[4] !== rom[8'h13]) begin
      fails++;
      $display("FAIL busy_start: got done@%0d issues %0d instr4 %h, exp 7 4 %h", done_idx, issue_count, tr_instr[4], rom[8'h13]);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_idle: got busy %b done %b, exp 0 0", busy, done);
    end
  endtask

  task automatic test_mid_reset();
    int ndone;
    @(negedge clk);
    pc_base  = 8'h30;
    prog_len = 8'd6;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({instr_out, instr_valid, stall, busy, done, imem_addr} !== {NOP, 4'b0000, 8'h00} ||
        issue_count !== 16'd0 || stall_count !== 16'd0) begin
      fails++;
      $display("FAIL midreset: got instr %h v%b s%b b%b d%b addr %h cnt %0d/%0d, exp reset values",
               instr_out, instr_valid, stall, busy, done, imem_addr, issue_count, stall_count);
    end
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL midreset_quiet: got %0d cycles busy/done after reset, exp 0", ndone);
    end
  endtask

  task automatic test_random();
    logic [7:0] base;
    int len, mdone, nissued, ncmp_bad;
    logic [17:0] ew;
    logic ev, es;
    for (int it = 0; it < 20; it++) begin
      base = 8'($urandom_range(0, 255));
      len  = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        rom[8'(base + i)] = mk($urandom_range(0, 7), $urandom_range(0, 3),
                               $urandom_range(0, 3), $urandom_range(0, 3));
      mdone = model_schedule(base, len);
      run_prog(base, 8'(len), -1, -1);
      tests++;
      if (done_idx != mdone) begin
        fails++;
        $display("FAIL rnd%0d_done: got done@%0d, exp %0d", it, done_idx, mdone);
      end
      nissued  = 0;
      ncmp_bad = 0;
      for (int k = 0; k < n_tr && k <= mdone; k++) begin
        ev = (nissued < len) && (d_idx[nissued] == k);
        ew = ev ? rom[8'(base + nissued)] : NOP;
        es = !ev && (k > d_idx[0]) && (k < d_idx[len-1]);
        if (ev) nissued++;
        if (tr_valid[k] !== ev || tr_instr[k] !== ew || tr_stall[k] !== es ||
            tr_addr[k] !== 8'(base + nissued) || tr_busy[k] !== (k != mdone)) begin
          ncmp_bad++;
          if (ncmp_bad <= 3)
            $display("FAIL rnd%0d_cycle%0d: got v%b %h s%b addr %h b%b, exp v%b %h s%b addr %h b%b",
                     it, k, tr_valid[k], tr_instr[k], tr_stall[k], tr_addr[k], tr_busy[k],
                     ev, ew, es, 8'(base + nissued), (k != mdone));
        end
      end
      tests++;
      if (ncmp_bad != 0) fails++;
      tests++;
      if (issue_count !== 16'(len) || stall_count !== 16'(d_idx[len-1] - len)) begin
        fails++;
        $display("FAIL rnd%0d_counts: got %0d/%0d, exp %0d/%0d", it, issue_count, stall_count,
                 len, d_idx[len-1] - len);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    test_reset();
    test_independent();
    test_raw_two_bubbles();
    test_raw_one_bubble();
    test_no_write();
    test_wrap();
    test_halt();
    test_len_zero();
    test_start_while_busy();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
